// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, default price table and price lookup for the vending block
//   state_t   : IDLE / CREDIT / VEND / REFUND
//   price_of  : extracts entry idx of width w from a flattened price table
package vend_pkg;
    typedef enum logic [1:0] {IDLE, CREDIT, VEND, REFUND} state_t;
    localparam logic [31:0] DEF_PRICES = {8'd12, 8'd10, 8'd7, 8'd5};
    localparam int MAX_TBL_W = 1024;
    function automatic logic [31:0] price_of(input logic [MAX_TBL_W-1:0] tbl, input int idx, input int w);
        return 32'((tbl >> (idx * w)) & ((MAX_TBL_W'(1) << w) - MAX_TBL_W'(1)));
    endfunction
endpackage

// File: rtl/vend_stock.sv
// vend_stock: per-item saturating stock counters with restock and vend decrement
//   clk, reset (async active-low)
//   restock_valid/restock_item/restock_qty : add units to one item
//   dec_valid/dec_item                     : remove one unit from one item
//   stock                                  : flattened counters, item i at [i*STOCK_W +: STOCK_W]
module vend_stock #(
    parameter int NUM_ITEMS  = 4,
    parameter int ITEM_W     = 2,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 3
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         restock_valid,
    input  logic [ITEM_W-1:0]            restock_item,
    input  logic [STOCK_W-1:0]           restock_qty,
    input  logic                         dec_valid,
    input  logic [ITEM_W-1:0]            dec_item,
    output logic [NUM_ITEMS*STOCK_W-1:0] stock
);
    localparam logic [STOCK_W-1:0] MAX = '1;
    logic [NUM_ITEMS*STOCK_W-1:0] nxt;
    // One extra bit so restock and decrement combine before saturating
    function automatic logic [STOCK_W-1:0] sat_upd(input logic [STOCK_W-1:0] s, input logic [STOCK_W-1:0] add, input logic sub);
        logic [STOCK_W:0] t;
        t = {1'b0, s} + {1'b0, add} - {{STOCK_W{1'b0}}, sub};
        return t > {1'b0, MAX} ? MAX : t[STOCK_W-1:0];
    endfunction
    always_comb begin
        nxt = stock;
        for (int k = 0; k < NUM_ITEMS; k++)
            nxt[k*STOCK_W +: STOCK_W] = sat_upd(stock[k*STOCK_W +: STOCK_W],
                (restock_valid && int'(restock_item) == k) ? restock_qty : '0,
                dec_valid && int'(dec_item) == k);
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) stock <= {NUM_ITEMS{STOCK_W'(INIT_STOCK)}};
        else stock <= nxt;
endmodule

// File: rtl/vend_fsm_multi.sv
// vend_fsm_multi: multi-coin vending controller with price table, stock and timeout refund
//   clk, reset (async active-low)
//   coin_valid/coin_value      : coin insertion
//   sel_valid/sel_item, cancel : keypad
//   restock_*                  : stock top-up
//   dispense/dispense_item, change_valid/change_amount : actuator pulses
//   credit, busy, coin_reject, err_funds, err_sold_out : status
module vend_fsm_multi
    import vend_pkg::*;
#(
    parameter int AMT_W       = 8,
    parameter int NUM_ITEMS   = 4,
    parameter int ITEM_W      = $clog2(NUM_ITEMS),
    parameter int STOCK_W     = 4,
    parameter int INIT_STOCK  = 3,
    parameter logic [NUM_ITEMS*AMT_W-1:0] PRICES = DEF_PRICES,
    parameter int TIMEOUT_CYC = 16
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               coin_valid,
    input  logic [AMT_W-1:0]   coin_value,
    input  logic               sel_valid,
    input  logic [ITEM_W-1:0]  sel_item,
    input  logic               cancel,
    input  logic               restock_valid,
    input  logic [ITEM_W-1:0]  restock_item,
    input  logic [STOCK_W-1:0] restock_qty,
    output logic               dispense,
    output logic [ITEM_W-1:0]  dispense_item,
    output logic               change_valid,
    output logic [AMT_W-1:0]   change_amount,
    output logic [AMT_W-1:0]   credit,
    output logic               busy,
    output logic               coin_reject,
    output logic               err_funds,
    output logic               err_sold_out
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    state_t state;
    logic [TMR_W-1:0] tmr;
    logic [NUM_ITEMS*STOCK_W-1:0] stock;
    logic [AMT_W:0] sum;
    logic [AMT_W-1:0] price;
    logic [STOCK_W-1:0] sel_stock;
    logic coin_in, accept, in_range, sold_out, short_funds, vend, refund;
    assign coin_in     = coin_valid && coin_value != '0;
    assign sum         = {1'b0, credit} + {1'b0, coin_value};
    assign accept      = coin_in && !sum[AMT_W];
    assign in_range    = int'(sel_item) < NUM_ITEMS;
    assign price       = AMT_W'(price_of(MAX_TBL_W'(PRICES), int'(sel_item), AMT_W));
    assign sel_stock   = in_range ? stock[int'(sel_item)*STOCK_W +: STOCK_W] : '0;
    assign sold_out    = sel_stock == '0;
    assign short_funds = credit < price;
    assign vend        = !cancel && sel_valid && !sold_out && !short_funds;
    // Timeout only fires on a cycle with no activity that would clear the counter
    assign refund      = cancel || (!sel_valid && !accept && tmr == TMR_W'(TIMEOUT_CYC - 1));
    // The latched item (dispense_item) drives the decrement during the VEND cycle
    vend_stock #(
        .NUM_ITEMS(NUM_ITEMS), .ITEM_W(ITEM_W), .STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)
    ) u_stock (
        .clk(clk), .reset(reset),
        .restock_valid(restock_valid), .restock_item(restock_item), .restock_qty(restock_qty),
        .dec_valid(state == VEND), .dec_item(dispense_item),
        .stock(stock)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            tmr           <= '0;
            credit        <= '0;
            dispense      <= 1'b0;
            dispense_item <= '0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            busy          <= 1'b0;
            coin_reject   <= 1'b0;
            err_funds     <= 1'b0;
            err_sold_out  <= 1'b0;
        end else begin
            dispense      <= 1'b0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            busy          <= 1'b0;
            coin_reject   <= 1'b0;
            err_funds     <= 1'b0;
            err_sold_out  <= 1'b0;
            case (state)
                IDLE: begin
                    err_funds <= sel_valid;
                    if (coin_in) begin
                        credit <= coin_value;
                        tmr    <= '0;
                        state  <= CREDIT;
                    end
                end
                CREDIT: begin
                    if (refund || vend) begin
                        state         <= vend ? VEND : REFUND;
                        busy          <= 1'b1;
                        dispense      <= vend;
                        change_valid  <= 1'b1;
                        change_amount <= vend ? credit - price : credit;
                        credit        <= '0;
                        coin_reject   <= coin_in;
                        if (vend) dispense_item <= sel_item;
                    end else begin
                        err_sold_out <= sel_valid && sold_out;
                        err_funds    <= sel_valid && !sold_out && short_funds;
                        coin_reject  <= coin_in && !accept;
                        if (accept) credit <= sum[AMT_W-1:0];
                        tmr <= (sel_valid || accept) ? '0 : tmr + 1'b1;
                    end
                end
                default: begin
                    coin_reject <= coin_in;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
